// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one SimpleBus memory port between the instruction
// fetch unit (read-only) and the load/store unit. One transaction is in
// flight at a time. Ties are settled either round-robin or with the LSU
// taking priority. A response timeout aborts the access and reports a bus
// error to the owner.
//
// Ports:
//   clk, rst                      clock (rising edge), async active-low reset
//   ifu_req_valid/ifu_raddr       fetch request in
//   ifu_req_ready                 fetch accepted this cycle (combinational)
//   ifu_resp_valid/ifu_rdata      fetch response, one-cycle pulse + held data
//   lsu_req_valid/wen/addr/wdata/wmask   load/store request in
//   lsu_req_ready                 LSU accepted this cycle (combinational)
//   lsu_resp_valid/lsu_rdata      load data / store ack, one-cycle pulse
//   mem_valid/wen/addr/wdata/wmask       request to memory (registered)
//   mem_ready, mem_rvalid, mem_rdata     memory handshake and read data
//   bus_err                       timeout pulse, coincident with resp_valid
module mem_arbiter #(
    parameter int unsigned ARB_MODE       = 0,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifu_req_valid,
    input  logic [31:0] ifu_raddr,
    output logic        ifu_req_ready,
    output logic        ifu_resp_valid,
    output logic [31:0] ifu_rdata,
    input  logic        lsu_req_valid,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wmask,
    output logic        lsu_req_ready,
    output logic        lsu_resp_valid,
    output logic [31:0] lsu_rdata,
    output logic        mem_valid,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_t;

    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYCLES);

    state_t           state;
    logic             last_lsu;   // 1: LSU was granted most recently
    logic             owner_lsu;  // owner of the in-flight access
    logic [CNT_W-1:0] cnt;
    logic             timeout_hit;
    logic             pick_ifu;
    logic             pick_lsu;

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == TO_VAL);

    // Grant decision; only acted upon while IDLE.
    always_comb begin
        pick_ifu = 1'b0;
        pick_lsu = 1'b0;
        if (ifu_req_valid && lsu_req_valid) begin
            if (ARB_MODE != 0) begin
                pick_lsu = 1'b1;
            end else if (last_lsu) begin
                pick_ifu = 1'b1;
            end else begin
                pick_lsu = 1'b1;
            end
        end else begin
            pick_ifu = ifu_req_valid;
            pick_lsu = lsu_req_valid;
        end
    end

    // Gated with rst so that every output reads 0 while reset is held.
    assign ifu_req_ready = rst && (state == IDLE) && pick_ifu;
    assign lsu_req_ready = rst && (state == IDLE) && pick_lsu;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            last_lsu       <= 1'b1;
            owner_lsu      <= 1'b0;
            cnt            <= '0;
            mem_valid      <= 1'b0;
            mem_wen        <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            mem_wmask      <= '0;
            ifu_resp_valid <= 1'b0;
            ifu_rdata      <= '0;
            lsu_resp_valid <= 1'b0;
            lsu_rdata      <= '0;
            bus_err        <= 1'b0;
        end else begin
            ifu_resp_valid <= 1'b0;
            lsu_resp_valid <= 1'b0;
            bus_err        <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_ifu) begin
                        owner_lsu <= 1'b0;
                        last_lsu  <= 1'b0;
                        mem_addr  <= ifu_raddr;
                        mem_wen   <= 1'b0;
                        mem_wdata <= '0;
                        mem_wmask <= '0;
                        mem_valid <= 1'b1;
                        cnt       <= '0;
                        state     <= REQ;
                    end else if (pick_lsu) begin
                        owner_lsu <= 1'b1;
                        last_lsu  <= 1'b1;
                        mem_addr  <= lsu_addr;
                        mem_wen   <= lsu_wen;
                        mem_wdata <= lsu_wdata;
                        mem_wmask <= lsu_wmask;
                        mem_valid <= 1'b1;
                        cnt       <= '0;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (timeout_hit) begin
                        mem_valid <= 1'b0;
                        bus_err   <= 1'b1;
                        state     <= IDLE;
                        if (owner_lsu) begin
                            lsu_resp_valid <= 1'b1;
                            lsu_rdata      <= '0;
                        end else begin
                            ifu_resp_valid <= 1'b1;
                            ifu_rdata      <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (mem_ready) begin
                            mem_valid <= 1'b0;
                            state     <= RESP;
                        end
                    end
                end
                RESP: begin
                    // A response landing on the timeout cycle still counts
                    // as a normal completion.
                    if (mem_rvalid) begin
                        state <= IDLE;
                        if (owner_lsu) begin
                            lsu_resp_valid <= 1'b1;
                            lsu_rdata      <= mem_rdata;
                        end else begin
                            ifu_resp_valid <= 1'b1;
                            ifu_rdata      <= mem_rdata;
                        end
                    end else if (timeout_hit) begin
                        bus_err <= 1'b1;
                        state   <= IDLE;
                        if (owner_lsu) begin
                            lsu_resp_valid <= 1'b1;
                            lsu_rdata      <= '0;
                        end else begin
                            ifu_resp_valid <= 1'b1;
                            ifu_rdata      <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter. Two instances share the clock:
//   index 0: round-robin, TIMEOUT_CYCLES=4
//   index 1: fixed priority (LSU wins), TIMEOUT_CYCLES=4
module tb_mem_arbiter;

    logic clk;
    logic rst [2];

    logic        iv [2];
    logic [31:0] ia [2];
    logic        lv [2];
    logic        lw [2];
    logic [31:0] la [2];
    logic [31:0] ld [2];
    logic [3:0]  lm [2];
    logic        mr [2];
    logic        rv [2];
    logic [31:0] rd [2];

    logic        ir  [2];
    logic        lr  [2];
    logic        irv [2];
    logic [31:0] ird [2];
    logic        lrv [2];
    logic [31:0] lrd [2];
    logic        mv  [2];
    logic        mw  [2];
    logic [31:0] ma  [2];
    logic [31:0] md  [2];
    logic [3:0]  mm  [2];
    logic        be  [2];

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.ARB_MODE(0), .TIMEOUT_CYCLES(4), .CNT_W(8)) u_rr (
        .clk(clk), .rst(rst[0]),
        .ifu_req_valid(iv[0]), .ifu_raddr(ia[0]), .ifu_req_ready(ir[0]),
        .ifu_resp_valid(irv[0]), .ifu_rdata(ird[0]),
        .lsu_req_valid(lv[0]), .lsu_wen(lw[0]), .lsu_addr(la[0]),
        .lsu_wdata(ld[0]), .lsu_wmask(lm[0]), .lsu_req_ready(lr[0]),
        .lsu_resp_valid(lrv[0]), .lsu_rdata(lrd[0]),
        .mem_valid(mv[0]), .mem_wen(mw[0]), .mem_addr(ma[0]),
        .mem_wdata(md[0]), .mem_wmask(mm[0]),
        .mem_ready(mr[0]), .mem_rvalid(rv[0]), .mem_rdata(rd[0]),
        .bus_err(be[0])
    );

    mem_arbiter #(.ARB_MODE(1), .TIMEOUT_CYCLES(4), .CNT_W(8)) u_fp (
        .clk(clk), .rst(rst[1]),
        .ifu_req_valid(iv[1]), .ifu_raddr(ia[1]), .ifu_req_ready(ir[1]),
        .ifu_resp_valid(irv[1]), .ifu_rdata(ird[1]),
        .lsu_req_valid(lv[1]), .lsu_wen(lw[1]), .lsu_addr(la[1]),
        .lsu_wdata(ld[1]), .lsu_wmask(lm[1]), .lsu_req_ready(lr[1]),
        .lsu_resp_valid(lrv[1]), .lsu_rdata(lrd[1]),
        .mem_valid(mv[1]), .mem_wen(mw[1]), .mem_addr(ma[1]),
        .mem_wdata(md[1]), .mem_wmask(mm[1]),
        .mem_ready(mr[1]), .mem_rvalid(rv[1]), .mem_rdata(rd[1]),
        .bus_err(be[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        // stimulus
        logic        iv;
        logic [31:0] ia;
        logic        lv;
        logic        lw;
        logic [31:0] la;
        logic [31:0] ld;
        logic [3:0]  lm;
        logic        mr;
        logic        rv;
        logic [31:0] rd;
        // expected
        logic        ir;
        logic        lr;
        logic        mv;
        logic        mw;
        logic [31:0] ma;
        logic [31:0] md;
        logic [3:0]  mm;
        logic        irv;
        logic [31:0] ird;
        logic        lrv;
        logic [31:0] lrd;
        logic        be;
    } vec_t;

    localparam logic        H  = 1'b1;
    localparam logic        L  = 1'b0;
    localparam logic [3:0]  M0 = 4'h0;
    localparam logic [3:0]  M3 = 4'b0011;
    localparam logic [31:0] Z  = 32'h0;
    localparam logic [31:0] IA = 32'h8000_0010;
    localparam logic [31:0] LA = 32'h8000_0200;
    localparam logic [31:0] IB = 32'h8000_0000;
    localparam logic [31:0] SA = 32'h8000_0100;
    localparam logic [31:0] SD = 32'hDEAD_BEEF;
    localparam logic [31:0] D1 = 32'h1111_1111;
    localparam logic [31:0] D2 = 32'h2222_2222;
    localparam logic [31:0] D3 = 32'h3333_3333;
    localparam logic [31:0] D4 = 32'h4444_4444;
    localparam logic [31:0] R4 = 32'h0000_0413;
    localparam logic [31:0] CF = 32'hCAFE_F00D;
    localparam logic [31:0] J1 = 32'hDEAD_0000;
    localparam logic [31:0] J2 = 32'hBAD0_0000;

    vec_t tbl [24];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input int d, input logic i_v, input logic [31:0] i_a,
                         input logic l_v, input logic l_w, input logic [31:0] l_a,
                         input logic [31:0] l_d, input logic [3:0] l_m,
                         input logic m_r, input logic r_v, input logic [31:0] r_d);
        iv[d] = i_v; ia[d] = i_a;
        lv[d] = l_v; lw[d] = l_w; la[d] = l_a; ld[d] = l_d; lm[d] = l_m;
        mr[d] = m_r; rv[d] = r_v; rd[d] = r_d;
    endtask

    task automatic chk_zero(input int d, input string tag);
        chk1 ($sformatf("%s d%0d ifu_req_ready", tag, d), ir[d], L);
        chk1 ($sformatf("%s d%0d lsu_req_ready", tag, d), lr[d], L);
        chk1 ($sformatf("%s d%0d ifu_resp_valid", tag, d), irv[d], L);
        chk32($sformatf("%s d%0d ifu_rdata", tag, d), ird[d], Z);
        chk1 ($sformatf("%s d%0d lsu_resp_valid", tag, d), lrv[d], L);
        chk32($sformatf("%s d%0d lsu_rdata", tag, d), lrd[d], Z);
        chk1 ($sformatf("%s d%0d mem_valid", tag, d), mv[d], L);
        chk1 ($sformatf("%s d%0d mem_wen", tag, d), mw[d], L);
        chk32($sformatf("%s d%0d mem_addr", tag, d), ma[d], Z);
        chk32($sformatf("%s d%0d mem_wdata", tag, d), md[d], Z);
        chk32($sformatf("%s d%0d mem_wmask", tag, d), {28'h0, mm[d]}, Z);
        chk1 ($sformatf("%s d%0d bus_err", tag, d), be[d], L);
    endtask

    initial begin
        // Round-robin instance: tie x4, IFU-only read with ignored stray
        // rvalids, then a store with a 3-cycle mem_ready stall whose
        // response lands exactly on the timeout cycle.
        //          iv ia lv lw la ld lm mr rv rd | ir lr mv mw ma md mm irv ird lrv lrd be
        tbl[0]  = '{H,IA,H,L,LA,Z,M0,H,L,Z,   H,L,L,L,Z, Z,M0,L,Z, L,Z, L};
        tbl[1]  = '{H,IA,H,L,LA,Z,M0,H,L,Z,   L,L,H,L,IA,Z,M0,L,Z, L,Z, L};
        tbl[2]  = '{H,IA,H,L,LA,Z,M0,H,H,D1,  L,L,L,L,IA,Z,M0,L,Z, L,Z, L};
        tbl[3]  = '{H,IA,H,L,LA,Z,M0,H,L,Z,   L,H,L,L,IA,Z,M0,H,D1,L,Z, L};
        tbl[4]  = '{H,IA,H,L,LA,Z,M0,H,L,Z,   L,L,H,L,LA,Z,M0,L,D1,L,Z, L};
        tbl[5]  = '{H,IA,H,L,LA,Z,M0,H,H,D2,  L,L,L,L,LA,Z,M0,L,D1,L,Z, L};
        tbl[6]  = '{H,IA,H,L,LA,Z,M0,H,L,Z,   H,L,L,L,LA,Z,M0,L,D1,H,D2,L};
        tbl[7]  = '{H,IA,H,L,LA,Z,M0,H,L,Z,   L,L,H,L,IA,Z,M0,L,D1,L,D2,L};
        tbl[8]  = '{H,IA,H,L,LA,Z,M0,H,H,D3,  L,L,L,L,IA,Z,M0,L,D1,L,D2,L};
        tbl[9]  = '{H,IA,H,L,LA,Z,M0,H,L,Z,   L,H,L,L,IA,Z,M0,H,D3,L,D2,L};
        tbl[10] = '{H,IA,H,L,LA,Z,M0,H,L,Z,   L,L,H,L,LA,Z,M0,L,D3,L,D2,L};
        tbl[11] = '{H,IA,H,L,LA,Z,M0,H,H,D4,  L,L,L,L,LA,Z,M0,L,D3,L,D2,L};
        tbl[12] = '{L,Z, L,L,Z, Z,M0,H,H,J1,  L,L,L,L,LA,Z,M0,L,D3,H,D4,L};
        tbl[13] = '{H,IB,L,L,Z, Z,M0,L,L,Z,   H,L,L,L,LA,Z,M0,L,D3,L,D4,L};
        tbl[14] = '{L,Z, L,L,Z, Z,M0,H,H,J2,  L,L,H,L,IB,Z,M0,L,D3,L,D4,L};
        tbl[15] = '{L,Z, L,L,Z, Z,M0,H,H,R4,  L,L,L,L,IB,Z,M0,L,D3,L,D4,L};
        tbl[16] = '{L,Z, L,L,Z, Z,M0,L,L,Z,   L,L,L,L,IB,Z,M0,H,R4,L,D4,L};
        tbl[17] = '{L,Z, H,H,SA,SD,M3,L,L,Z,  L,H,L,L,IB,Z,M0,L,R4,L,D4,L};
        tbl[18] = '{L,Z, L,L,Z, Z,M0,L,L,Z,   L,L,H,H,SA,SD,M3,L,R4,L,D4,L};
        tbl[19] = '{L,Z, L,L,Z, Z,M0,L,L,Z,   L,L,H,H,SA,SD,M3,L,R4,L,D4,L};
        tbl[20] = '{L,Z, L,L,Z, Z,M0,L,L,Z,   L,L,H,H,SA,SD,M3,L,R4,L,D4,L};
        tbl[21] = '{L,Z, L,L,Z, Z,M0,H,L,Z,   L,L,H,H,SA,SD,M3,L,R4,L,D4,L};
        tbl[22] = '{L,Z, L,L,Z, Z,M0,L,H,CF,  L,L,L,H,SA,SD,M3,L,R4,L,D4,L};
        tbl[23] = '{L,Z, L,L,Z, Z,M0,L,L,Z,   L,L,L,H,SA,SD,M3,L,R4,H,CF,L};

        // Reset state
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b0;
            drive(d, L, Z, L, L, Z, Z, M0, L, L, Z);
        end
        #3;
        chk_zero(0, "reset");
        chk_zero(1, "reset");
        @(negedge clk);
        rst[0] = 1'b1;
        rst[1] = 1'b1;

        // Table-driven run on the round-robin instance
        for (int i = 0; i < 24; i++) begin
            drive(0, tbl[i].iv, tbl[i].ia, tbl[i].lv, tbl[i].lw, tbl[i].la,
                  tbl[i].ld, tbl[i].lm, tbl[i].mr, tbl[i].rv, tbl[i].rd);
            #1;
            chk1 ($sformatf("v%0d ifu_req_ready", i), ir[0], tbl[i].ir);
            chk1 ($sformatf("v%0d lsu_req_ready", i), lr[0], tbl[i].lr);
            chk1 ($sformatf("v%0d mem_valid", i), mv[0], tbl[i].mv);
            chk1 ($sformatf("v%0d mem_wen", i), mw[0], tbl[i].mw);
            chk32($sformatf("v%0d mem_addr", i), ma[0], tbl[i].ma);
            chk32($sformatf("v%0d mem_wdata", i), md[0], tbl[i].md);
            chk32($sformatf("v%0d mem_wmask", i), {28'h0, mm[0]}, {28'h0, tbl[i].mm});
            chk1 ($sformatf("v%0d ifu_resp_valid", i), irv[0], tbl[i].irv);
            chk32($sformatf("v%0d ifu_rdata", i), ird[0], tbl[i].ird);
            chk1 ($sformatf("v%0d lsu_resp_valid", i), lrv[0], tbl[i].lrv);
            chk32($sformatf("v%0d lsu_rdata", i), lrd[0], tbl[i].lrd);
            chk1 ($sformatf("v%0d bus_err", i), be[0], tbl[i].be);
            @(negedge clk);
        end

        // Fixed priority: LSU wins every tie; IFU only after LSU drops.
        for (int k = 0; k < 3; k++) begin
            drive(1, H, IA, H, L, 32'h8000_0300, Z, M0, H, L, Z);
            #1;
            chk1($sformatf("fp%0d lsu_req_ready", k), lr[1], H);
            chk1($sformatf("fp%0d ifu_req_ready", k), ir[1], L);
            if (k > 0) begin
                chk1 ($sformatf("fp%0d lsu_resp_valid", k), lrv[1], H);
                chk32($sformatf("fp%0d lsu_rdata", k), lrd[1], 32'(32'hA0 + k - 1));
                chk1 ($sformatf("fp%0d ifu_resp_valid", k), irv[1], L);
            end
            @(negedge clk);
            #1;
            chk1 ($sformatf("fp%0d mem_valid", k), mv[1], H);
            chk32($sformatf("fp%0d mem_addr", k), ma[1], 32'h8000_0300);
            @(negedge clk);
            drive(1, H, IA, H, L, 32'h8000_0300, Z, M0, H, H, 32'(32'hA0 + k));
            @(negedge clk);
        end
        drive(1, H, IA, L, L, Z, Z, M0, H, L, Z);
        #1;
        chk1 ("fp_end ifu_req_ready", ir[1], H);
        chk1 ("fp_end lsu_req_ready", lr[1], L);
        chk1 ("fp_end lsu_resp_valid", lrv[1], H);
        chk32("fp_end lsu_rdata", lrd[1], 32'h0000_00A2);
        @(negedge clk);
        drive(1, L, Z, L, L, Z, Z, M0, H, L, Z);
        #1;
        chk32("fp_ifu mem_addr", ma[1], IA);
        @(negedge clk);
        drive(1, L, Z, L, L, Z, Z, M0, L, H, 32'h0000_0055);
        @(negedge clk);
        drive(1, L, Z, L, L, Z, Z, M0, L, L, Z);
        #1;
        chk1 ("fp_ifu ifu_resp_valid", irv[1], H);
        chk32("fp_ifu ifu_rdata", ird[1], 32'h0000_0055);
        chk32("fp_ifu lsu_rdata kept", lrd[1], 32'h0000_00A2);

        // Timeout on the round-robin instance: memory never answers.
        @(negedge clk);
        drive(0, H, 32'h8000_0040, L, L, Z, Z, M0, L, L, Z);
        #1;
        chk1("to ifu_req_ready", ir[0], H);
        @(negedge clk);
        drive(0, L, Z, L, L, Z, Z, M0, H, L, Z);
        #1;
        chk1("to mem_valid", mv[0], H);
        @(negedge clk);
        for (int j = 2; j <= 5; j++) begin
            drive(0, L, Z, L, L, Z, Z, M0, L, L, Z);
            #1;
            chk1($sformatf("to c%0d mem_valid", j), mv[0], L);
            chk1($sformatf("to c%0d ifu_resp_valid", j), irv[0], L);
            chk1($sformatf("to c%0d bus_err", j), be[0], L);
            @(negedge clk);
        end
        drive(0, L, Z, H, L, 32'h8000_0500, Z, M0, L, L, Z);
        #1;
        chk1 ("to ifu_resp_valid", irv[0], H);
        chk32("to ifu_rdata", ird[0], Z);
        chk1 ("to bus_err", be[0], H);
        chk1 ("to lsu_resp_valid", lrv[0], L);
        chk1 ("to next lsu_req_ready", lr[0], H);
        @(negedge clk);
        drive(0, L, Z, L, L, Z, Z, M0, H, L, Z);
        #1;
        chk1 ("to+1 bus_err", be[0], L);
        chk1 ("to+1 ifu_resp_valid", irv[0], L);
        chk1 ("to+1 mem_valid", mv[0], H);
        chk32("to+1 mem_addr", ma[0], 32'h8000_0500);
        @(negedge clk);
        drive(0, L, Z, L, L, Z, Z, M0, L, H, 32'h1234_5678);
        @(negedge clk);
        drive(0, L, Z, L, L, Z, Z, M0, L, L, Z);
        #1;
        chk1 ("to+3 lsu_resp_valid", lrv[0], H);
        chk32("to+3 lsu_rdata", lrd[0], 32'h1234_5678);
        chk1 ("to+3 bus_err", be[0], L);

        // Reset asserted while waiting in RESP.
        @(negedge clk);
        drive(0, H, 32'h8000_0080, L, L, Z, Z, M0, L, L, Z);
        #1;
        chk1("rs ifu_req_ready", ir[0], H);
        @(negedge clk);
        drive(0, L, Z, L, L, Z, Z, M0, H, L, Z);
        @(negedge clk);
        drive(0, H, IA, H, L, LA, Z, M0, L, H, 32'h7777_7777);
        #1;
        rst[0] = 1'b0;
        #1;
        chk_zero(0, "rs_async");
        @(negedge clk);
        #1;
        chk_zero(0, "rs_held");
        @(negedge clk);
        rst[0] = 1'b1;
        drive(0, L, Z, L, L, Z, Z, M0, L, L, Z);
        for (int j = 0; j < 2; j++) begin
            #1;
            chk1($sformatf("rs_post%0d ifu_resp_valid", j), irv[0], L);
            chk1($sformatf("rs_post%0d lsu_resp_valid", j), lrv[0], L);
            chk1($sformatf("rs_post%0d mem_valid", j), mv[0], L);
            @(negedge clk);
        end
        drive(0, H, IA, H, L, LA, Z, M0, H, L, Z);
        #1;
        chk1("rs_tie ifu_req_ready", ir[0], H);
        chk1("rs_tie lsu_req_ready", lr[0], L);
        @(negedge clk);
        drive(0, L, Z, L, L, Z, Z, M0, L, L, Z);
        #1;
        chk32("rs_tie mem_addr", ma[0], IA);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter that shares the single SimpleBus memory port between the IFU (instruction fetch, read-only) and the LSU (loads/stores).
- Sits between the IFU/LSU and the memory model.
- Serialises accesses with one outstanding transaction, round-robin or fixed-priority grant, and a response timeout that reports a bus error.

Parameters:
- ARB_MODE, 0: 0 = round-robin, 1 = fixed priority, LSU wins.
- TIMEOUT_CYCLES, 255: maximum cycles from mem_valid assertion to mem_rvalid. 0 disables the timeout.
- CNT_W, 8: width of the timeout counter. Must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- ifu_req_valid  in  1  IFU fetch request.
- ifu_raddr  in  32  fetch address.
- ifu_req_ready  out  1  fetch request accepted this cycle.
- ifu_resp_valid  out  1  fetch data valid, one-cycle pulse.
- ifu_rdata  out  32  fetched instruction.
- lsu_req_valid  in  1  LSU request.
- lsu_wen  in  1  1 = store, 0 = load.
- lsu_addr  in  32  access address.
- lsu_wdata  in  32  store data.
- lsu_wmask  in  4  byte write mask.
- lsu_req_ready  out  1  LSU request accepted this cycle.
- lsu_resp_valid  out  1  load data / store ack, one-cycle pulse.
- lsu_rdata  out  32  load data.
- mem_valid  out  1  request to memory.
- mem_wen  out  1  write enable.
- mem_addr  out  32  address.
- mem_wdata  out  32  write data.
- mem_wmask  out  4  write mask.
- mem_ready  in  1  memory accepted the request.
- mem_rvalid  in  1  read data / write ack valid.
- mem_rdata  in  32  read data.
- bus_err  out  1  timeout pulse, one cycle, coincident with the owner's resp_valid.

Behaviour:
- Reset (rst=0, async): state=IDLE; last_grant=LSU so IFU wins the first tie; timeout counter=0. All outputs 0, including rdata buses and mem_* outputs.
- States:
  - IDLE: pick a requester. ifu_req_ready/lsu_req_ready are combinational, high only in IDLE for the granted requester and only when its valid is high.
  - On acceptance, latch addr/wen/wdata/wmask and owner into registers, update last_grant, go to REQ. IFU requests latch wen=0, wmask=0.
  - REQ: mem_valid=1 with the latched fields, held stable until mem_ready. On mem_ready go to RESP; mem_valid drops the next cycle.
  - RESP: wait for mem_rvalid. On mem_rvalid, capture mem_rdata into the owner's rdata register, pulse the owner's resp_valid the next cycle, go to IDLE.
- Grant:
  - ARB_MODE=0: a single requester wins. If both request, the one not in last_grant wins.
  - ARB_MODE=1: LSU wins any tie.
  - The non-granted requester keeps valid high and is served in a later IDLE.
- Latency, mem_ready and mem_rvalid both immediate:
  - accept in cycle 0, mem_valid in cycle 1, mem_rvalid in cycle 2, resp_valid in cycle 3.
  - The cycle resp_valid is high, state is already IDLE and a new request can be accepted, giving back-to-back throughput of one access per 3 cycles.
- rdata registers hold their value until the next response to the same owner. The other owner's rdata is untouched.
- Stores also wait for mem_rvalid as the write ack. lsu_rdata on a store response = mem_rdata as captured; the LSU ignores it.
- Timeout:
  - The counter clears on entry to REQ and increments every cycle in REQ or RESP.
  - When it equals TIMEOUT_CYCLES (TIMEOUT_CYCLES≠0), abort: mem_valid drops, go to IDLE.
  - Next cycle, the owner sees resp_valid=1, rdata=0, bus_err=1.
  - mem_rvalid arriving in the same cycle as the timeout wins: it is a normal response with no error.
- mem_rvalid or mem_ready outside their waiting state are ignored.
- Reset mid-operation: immediate return to IDLE, outputs 0. The in-flight access is dropped and no response is produced.

Test Plan:
- Reset, then IFU-only read of 0x8000_0000, memory returns 0x0000_0413 with 0-wait → ifu_req_ready in cycle 0, mem_valid in cycle 1 with mem_wen=0, ifu_resp_valid with ifu_rdata=0x0000_0413 in cycle 3, lsu_resp_valid stays 0.
- IFU and LSU both request in the same cycle, ARB_MODE=0 → IFU is served first. Hold both valid for 4 transactions → grants alternate IFU, LSU, IFU, LSU.
- ARB_MODE=1 with the same stimulus → LSU is granted every time. IFU is served only once LSU drops valid.
- LSU store: addr 0x8000_0100, wdata 0xDEADBEEF, wmask 4'b0011, with mem_ready delayed 3 cycles → mem_* fields stay stable through the stall, lsu_resp_valid fires one cycle after mem_rvalid.
- TIMEOUT_CYCLES=4, memory never asserts mem_rvalid → owner resp_valid=1, rdata=0, bus_err=1 for one cycle. The next request is accepted normally.
- Assert rst=0 mid-RESP → all outputs 0 asynchronously, no resp_valid after release. The first post-reset tie goes to IFU.
